// File: rtl/mult_pkg.sv
// Shared types and constants for the unsigned multiplier datapath: the operand receiver and the
// product serializer both size themselves from MULT_OPERAND_W.
package mult_pkg;

    localparam int unsigned MULT_OPERAND_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFTING,
        HOLD
    } rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// Saturating frame bit counter for the operand receiver; `last` flags that the bit sampled on the
// coming edge completes a frame of FRAME_LEN bits.
module rx_bit_counter #(
    parameter int unsigned FRAME_LEN = 12,
    parameter int unsigned CW        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign last = (count_q == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/serial_operand_rx.sv
// LSB-first serial-to-parallel operand receiver feeding the multiplier core.
// Define SERIAL_OPERAND_RX_PARITY_EN to append and check an even-parity bit after the data bits.
module serial_operand_rx
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_OPERAND_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_in,
    input  logic             fx,
    output logic [WIDTH-1:0] x_parallel,
    output logic             sx,
    output logic             err
);

`ifdef SERIAL_OPERAND_RX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_LEN = WIDTH + PAR_BITS;
    localparam int unsigned CW        = $clog2(WIDTH + 2);
    // Without parity the final bit is taken straight from x_in, so one register bit fewer.
    localparam int unsigned SR_W      = WIDTH - 1 + PAR_BITS;

    rx_state_t        state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0] x_parallel_q, x_parallel_d;
    logic             sx_q, sx_d;
    logic             err_q, err_d;
    logic             cnt_clear, cnt_inc, cnt_last;
    logic [SR_W-1:0]  shifted;

    rx_bit_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    // New bit enters at the MSB and everything moves one place toward bit 0.
    assign shifted = SR_W'({x_in, sr_q} >> 1);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        x_parallel_d = x_parallel_q;
        sx_d         = 1'b0;
        err_d        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fx) begin
                    cnt_inc = 1'b1;
                    sr_d    = SR_W'({x_in, SR_W'(0)} >> 1);
                    state_d = SHIFTING;
                end else begin
                    cnt_clear = 1'b1;
                end
            end
            SHIFTING: begin
                if (!fx) begin
                    err_d     = 1'b1;
                    sr_d      = '0;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_last) begin
                    cnt_inc = 1'b1;
                    sr_d    = '0;
                    state_d = HOLD;
`ifdef SERIAL_OPERAND_RX_PARITY_EN
                    if (^{sr_q, x_in} == 1'b0) begin
                        x_parallel_d = sr_q;
                        sx_d         = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    x_parallel_d = {x_in, sr_q};
                    sx_d         = 1'b1;
`endif
                end else begin
                    cnt_inc = 1'b1;
                    sr_d    = shifted;
                end
            end
            HOLD: begin
                cnt_clear = 1'b1;
                if (!fx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_clear = 1'b1;
                sr_d      = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            x_parallel_q <= '0;
            sx_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            x_parallel_q <= x_parallel_d;
            sx_q         <= sx_d;
            err_q        <= err_d;
        end
    end

    assign x_parallel = x_parallel_q;
    assign sx         = sx_q;
    assign err        = err_q;

endmodule

// File: tb/tb_serial_operand_rx.sv
// Scoreboard bench for serial_operand_rx: frame outcomes predicted from frame length and parity,
// a separate monitor matches them against sx/err pulses.
module tb_serial_operand_rx;

    localparam int W = 12;
`ifdef SERIAL_OPERAND_RX_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        bit           is_err;
        logic [W-1:0] val;
        int           start;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         x_in;
    logic         fx;
    logic [W-1:0] x_parallel;
    logic         sx;
    logic         err;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    serial_operand_rx #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .fx         (fx),
        .x_parallel (x_parallel),
        .sx         (sx),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drives one frame: nbits cycles with fx high, then `gap` idle cycles. reset_at >= 0 pulses
    // reset instead of driving that bit and abandons the frame.
    task automatic send_frame(input logic [W-1:0] data, input int nbits, input bit bad_par,
                              input int reset_at, input int gap);
        exp_t e;
        logic [W-1:0] d;
        d = data;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 0 && reset_at < 0) begin
                e.start = cyc;
                if (nbits < FL) begin
                    e.is_err = 1'b1;
                    e.val    = '0;
                end else if (PAR && ((^d) ^ bad_par) != (^d)) begin
                    e.is_err = 1'b1;
                    e.val    = '0;
                end else begin
                    e.is_err = 1'b0;
                    e.val    = d;
                end
                q.push_back(e);
            end
            if (i == reset_at) begin
                fx    = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            fx = 1'b1;
            if (i < W) x_in = d[i];
            else if (PAR && i == W) x_in = (^d) ^ bad_par;
            else x_in = 1'($urandom);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            fx   = 1'b0;
            x_in = 1'($urandom);
        end
    endtask

    // Monitor: x_parallel must track the last successfully received operand.
    initial begin
        logic [W-1:0] cur;
        exp_t e;
        cur = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                cur = '0;
                chk(x_parallel == '0, "reset_xpar", 32'(x_parallel), 0);
                chk(!sx && !err, "reset_pulses", {30'd0, sx, err}, 0);
            end else begin
                if (sx && err) chk(1'b0, "sx_err_together", {30'd0, sx, err}, 32'd1);
                if (sx || err) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_pulse", {30'd0, sx, err}, 0);
                    end else begin
                        e = q.pop_front();
                        if (e.is_err) begin
                            chk(err && !sx, "err_pulse", {30'd0, sx, err}, 32'd1);
                            chk(x_parallel == cur, "err_xpar_kept", 32'(x_parallel), 32'(cur));
                        end else begin
                            chk(sx && !err, "sx_pulse", {30'd0, sx, err}, 32'd2);
                            chk(x_parallel == e.val, "sx_data", 32'(x_parallel), 32'(e.val));
                            chk(cyc - e.start == FL, "sx_latency", 32'(cyc - e.start),
                                32'(FL));
                            cur = e.val;
                        end
                    end
                end else begin
                    chk(x_parallel == cur, "xpar_stable", 32'(x_parallel), 32'(cur));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] data;
        int nbits, kind, rst_at;
        bit bad;
        reset = 1'b1;
        fx    = 1'b0;
        x_in  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_frame(12'hA5C, FL, 1'b0, -1, 2);
        send_frame(12'hFFF, 7, 1'b0, -1, 2);
        send_frame(12'h123, 20, 1'b0, -1, 1);
        send_frame(12'h0F0, FL, 1'b0, -1, 2);
        send_frame(12'h777, FL, 1'b0, 5, 2);
        send_frame(12'h001, FL, 1'b0, -1, 2);
        if (PAR) begin
            send_frame(12'h003, FL, 1'b0, -1, 2);
            send_frame(12'h003, FL, 1'b1, -1, 2);
        end

        for (int n = 0; n < 60; n++) begin
            data = W'($urandom);
            kind = int'($urandom_range(0, 3));
            if (kind == 2) nbits = int'($urandom_range(1, FL - 1));
            else if (kind == 3) nbits = FL + int'($urandom_range(1, 6));
            else nbits = FL;
            bad    = PAR ? 1'($urandom_range(0, 1)) : 1'b0;
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, nbits - 1)) : -1;
            send_frame(data, nbits, bad, rst_at, int'($urandom_range(2, 3)));
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(q.size() == 0, "drain", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
